// File: rtl/collatz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_pkg
//  Description : Shared state enum, ALU/mux/decoder/shift codes and the
//                state-to-control-word decoder for the Collatz control unit
//                and its 8-bit micro-datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package collatz_pkg;

    typedef enum logic [4:0] {
        S_IDLE, S_CLR1, S_CLR3, S_ONE_A, S_ONE_W, S_SEED_A, S_SEED_W,
        S_TEST_ONE, S_TEST_PAR, S_EVEN_A, S_EVEN_S, S_EVEN_W,
        S_ODD1_A, S_ODD1_W, S_ODD2_A, S_ODD2_W, S_ODD3_A, S_ODD3_W,
        S_CNT_A, S_CNT_W, S_DONE, S_ERR
    } state_t;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_SUB    = 4'b0010;
    localparam logic [3:0] ALU_AND    = 4'b0011;
    localparam logic [3:0] ALU_INC_A  = 4'b0100;

    localparam logic [2:0] SRC_R0 = 3'd0;
    localparam logic [2:0] SRC_R1 = 3'd1;
    localparam logic [2:0] SRC_R2 = 3'd2;
    localparam logic [2:0] SRC_R3 = 3'd3;
    localparam logic [2:0] SRC_F0 = 3'd4;
    localparam logic [2:0] SRC_F1 = 3'd5;

    localparam logic [2:0] DEC_R0   = 3'd0;
    localparam logic [2:0] DEC_R1   = 3'd1;
    localparam logic [2:0] DEC_R2   = 3'd2;
    localparam logic [2:0] DEC_R3   = 3'd3;
    localparam logic [2:0] DEC_NONE = 3'b111;

    localparam logic [1:0] SHIFT_NONE  = 2'b11;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;

    // Complete control word presented to the datapath
    typedef struct packed {
        logic [2:0] decClr;
        logic [2:0] decLd;
        logic [2:0] muxA;
        logic [2:0] muxB;
        logic [3:0] alu;
        logic       shClrN;
        logic       shLdN;
        logic [1:0] shift;
        logic       busy;
        logic       done;
        logic       error;
    } ctrl_t;

    // Moore decode: every control line is a function of the state alone
    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c.decClr = DEC_NONE;
        c.decLd  = DEC_NONE;
        c.muxA   = SRC_R0;
        c.muxB   = SRC_R0;
        c.alu    = ALU_PASS_A;
        c.shClrN = 1'b1;
        c.shLdN  = 1'b1;
        c.shift  = SHIFT_NONE;
        c.busy   = (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
        c.done   = 1'b0;
        c.error  = 1'b0;
        case (s)
            S_CLR1:     c.decClr = DEC_R1;
            S_CLR3:     c.decClr = DEC_R3;
            S_ONE_A:    begin c.muxA = SRC_R1; c.alu = ALU_INC_A; c.shLdN = 1'b0; end
            S_ONE_W:    c.decLd = DEC_R1;
            S_SEED_A:   begin c.muxA = SRC_F0; c.alu = ALU_PASS_A; c.shLdN = 1'b0; end
            S_SEED_W:   c.decLd = DEC_R0;
            S_TEST_ONE: begin c.muxA = SRC_R0; c.muxB = SRC_R1; c.alu = ALU_SUB; end
            S_TEST_PAR: begin c.muxA = SRC_R0; c.muxB = SRC_R1; c.alu = ALU_AND; end
            S_EVEN_A:   begin c.muxA = SRC_R0; c.alu = ALU_PASS_A; c.shLdN = 1'b0; end
            S_EVEN_S:   c.shift = SHIFT_RIGHT;
            S_EVEN_W:   c.decLd = DEC_R0;
            S_ODD1_A:   begin c.muxA = SRC_R0; c.muxB = SRC_R0; c.alu = ALU_ADD; c.shLdN = 1'b0; end
            S_ODD1_W:   c.decLd = DEC_R2;
            S_ODD2_A:   begin c.muxA = SRC_R2; c.muxB = SRC_R0; c.alu = ALU_ADD; c.shLdN = 1'b0; end
            S_ODD2_W:   c.decLd = DEC_R2;
            S_ODD3_A:   begin c.muxA = SRC_R2; c.alu = ALU_INC_A; c.shLdN = 1'b0; end
            S_ODD3_W:   c.decLd = DEC_R0;
            S_CNT_A:    begin c.muxA = SRC_R3; c.alu = ALU_INC_A; c.shLdN = 1'b0; end
            S_CNT_W:    c.decLd = DEC_R3;
            S_DONE:     c.done  = 1'b1;
            S_ERR:      c.error = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ucontrol_collatz.sv
`default_nettype none
// ============================================================================
//  Module      : ucontrol_collatz
//  Description : Moore control unit running the Collatz iteration on seed F0
//                through the 8-bit micro-datapath; step count lands in R3.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucontrol_collatz
    import collatz_pkg::*;
#(
    parameter int DATAWIDTH_DECODER_SELECTION = 3,
    parameter int DATAWIDTH_MUX_SELECTION     = 3,
    parameter int DATAWIDTH_ALU_SELECTION     = 4
) (
    input  logic                                   uCONTROL_CLOCK_50,
    input  logic                                   uCONTROL_RESET_InLow,
    input  logic                                   uCONTROL_start_InHigh,
    input  logic                                   uCONTROL_zero_InLow,
    input  logic                                   uCONTROL_carry_InLow,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderclearselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderloadselection_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     uCONTROL_muxselectionBUSA_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     uCONTROL_muxselectionBUSB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCONTROL_aluselection_OutBUS,
    output logic                                   uCONTROL_regSHIFTERclear_OutLow,
    output logic                                   uCONTROL_regSHIFTERload_OutLow,
    output logic [1:0]                             uCONTROL_regSHIFTERshiftselection_OutLow,
    output logic                                   uCONTROL_busy_OutHigh,
    output logic                                   uCONTROL_done_OutHigh,
    output logic                                   uCONTROL_error_OutHigh
);

    state_t r_state;
    state_t w_nextState;
    ctrl_t  r_ctrl;
    logic   w_zero;
    logic   w_carry;

    assign w_zero  = ~uCONTROL_zero_InLow;
    assign w_carry = ~uCONTROL_carry_InLow;

    // Next-state selection; datapath flags only steer *_A and test states
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (uCONTROL_start_InHigh) w_nextState = S_CLR1;
            S_CLR1:     w_nextState = S_CLR3;
            S_CLR3:     w_nextState = S_ONE_A;
            S_ONE_A:    w_nextState = S_ONE_W;
            S_ONE_W:    w_nextState = S_SEED_A;
            S_SEED_A:   w_nextState = w_zero ? S_ERR : S_SEED_W;
            S_SEED_W:   w_nextState = S_TEST_ONE;
            S_TEST_ONE: w_nextState = w_zero ? S_DONE : S_TEST_PAR;
            S_TEST_PAR: w_nextState = w_zero ? S_EVEN_A : S_ODD1_A;
            S_EVEN_A:   w_nextState = S_EVEN_S;
            S_EVEN_S:   w_nextState = S_EVEN_W;
            S_EVEN_W:   w_nextState = S_CNT_A;
            S_ODD1_A:   w_nextState = w_carry ? S_ERR : S_ODD1_W;
            S_ODD1_W:   w_nextState = S_ODD2_A;
            S_ODD2_A:   w_nextState = w_carry ? S_ERR : S_ODD2_W;
            S_ODD2_W:   w_nextState = S_ODD3_A;
            S_ODD3_A:   w_nextState = w_carry ? S_ERR : S_ODD3_W;
            S_ODD3_W:   w_nextState = S_CNT_A;
            // R3 wrapping past 255 shows up as the INC carry here
            S_CNT_A:    w_nextState = w_carry ? S_ERR : S_CNT_W;
            S_CNT_W:    w_nextState = S_TEST_ONE;
            S_DONE,
            S_ERR:      if (uCONTROL_start_InHigh) w_nextState = S_CLR1;
            default:    w_nextState = S_IDLE;
        endcase
    end

    // State register; the control word is registered from the next state so
    // outputs always equal decodeState(r_state) with no decode glitches
    always_ff @(posedge uCONTROL_CLOCK_50 or negedge uCONTROL_RESET_InLow) begin
        if (!uCONTROL_RESET_InLow) begin
            r_state <= S_IDLE;
            r_ctrl  <= decodeState(S_IDLE);
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= decodeState(w_nextState);
        end
    end

    assign uCONTROL_decoderclearselection_OutBUS    = r_ctrl.decClr;
    assign uCONTROL_decoderloadselection_OutBUS     = r_ctrl.decLd;
    assign uCONTROL_muxselectionBUSA_OutBUS         = r_ctrl.muxA;
    assign uCONTROL_muxselectionBUSB_OutBUS         = r_ctrl.muxB;
    assign uCONTROL_aluselection_OutBUS             = r_ctrl.alu;
    assign uCONTROL_regSHIFTERclear_OutLow          = r_ctrl.shClrN;
    assign uCONTROL_regSHIFTERload_OutLow           = r_ctrl.shLdN;
    assign uCONTROL_regSHIFTERshiftselection_OutLow = r_ctrl.shift;
    assign uCONTROL_busy_OutHigh                    = r_ctrl.busy;
    assign uCONTROL_done_OutHigh                    = r_ctrl.done;
    assign uCONTROL_error_OutHigh                   = r_ctrl.error;

endmodule

`default_nettype wire

// File: tb/tb_ucontrol_collatz.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucontrol_collatz
//  Description : Directed bench for ucontrol_collatz driving a behavioural
//                8-bit micro-datapath (R0..R3, F0 seed, F1 zero, ALU, shifter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucontrol_collatz;
    import collatz_pkg::*;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       zeroN;
    logic       carryN;
    logic [2:0] decClr, decLd, muxA, muxB;
    logic [3:0] aluSel;
    logic       shClrN, shLdN;
    logic [1:0] shiftSel;
    logic       busy, done, error;

    logic [7:0] seed;
    logic [7:0] dpR [4] = '{default: 8'h00};
    logic [7:0] shReg = 8'h00;
    logic [7:0] busA, busB;
    logic [8:0] aluRes;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    ucontrol_collatz dut (
        .uCONTROL_CLOCK_50                        (clk),
        .uCONTROL_RESET_InLow                     (rstN),
        .uCONTROL_start_InHigh                    (start),
        .uCONTROL_zero_InLow                      (zeroN),
        .uCONTROL_carry_InLow                     (carryN),
        .uCONTROL_decoderclearselection_OutBUS    (decClr),
        .uCONTROL_decoderloadselection_OutBUS     (decLd),
        .uCONTROL_muxselectionBUSA_OutBUS         (muxA),
        .uCONTROL_muxselectionBUSB_OutBUS         (muxB),
        .uCONTROL_aluselection_OutBUS             (aluSel),
        .uCONTROL_regSHIFTERclear_OutLow          (shClrN),
        .uCONTROL_regSHIFTERload_OutLow           (shLdN),
        .uCONTROL_regSHIFTERshiftselection_OutLow (shiftSel),
        .uCONTROL_busy_OutHigh                    (busy),
        .uCONTROL_done_OutHigh                    (done),
        .uCONTROL_error_OutHigh                   (error)
    );

    function automatic logic [7:0] srcSel(input logic [2:0] s);
        case (s)
            SRC_R0:  return dpR[0];
            SRC_R1:  return dpR[1];
            SRC_R2:  return dpR[2];
            SRC_R3:  return dpR[3];
            SRC_F0:  return seed;
            default: return 8'h00;
        endcase
    endfunction

    // Datapath ALU and its active-low flags
    always_comb begin
        busA   = srcSel(muxA);
        busB   = srcSel(muxB);
        aluRes = 9'h000;
        case (aluSel)
            ALU_PASS_A: aluRes = {1'b0, busA};
            ALU_ADD:    aluRes = {1'b0, busA} + {1'b0, busB};
            ALU_SUB:    aluRes = {1'b0, busA} - {1'b0, busB};
            ALU_AND:    aluRes = {1'b0, busA & busB};
            ALU_INC_A:  aluRes = {1'b0, busA} + 9'd1;
            default:    aluRes = 9'h000;
        endcase
        zeroN  = (aluRes[7:0] != 8'h00);
        carryN = ~aluRes[8];
    end

    // Datapath shifter register and register file
    always @(posedge clk) begin
        if (!shClrN)                  shReg <= 8'h00;
        else if (!shLdN)              shReg <= aluRes[7:0];
        else if (shiftSel == SHIFT_RIGHT) shReg <= shReg >> 1;
        else if (shiftSel == SHIFT_LEFT)  shReg <= shReg << 1;
        if (decClr != DEC_NONE) dpR[decClr[1:0]] <= 8'h00;
        if (decLd  != DEC_NONE) dpR[decLd[1:0]]  <= shReg;
    end

    localparam logic [22:0] IDLE_WORD =
        {3'b111, 3'b111, 3'b000, 3'b000, 4'b0000, 1'b1, 1'b1, 2'b11, 3'b000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] outWord();
        return {decClr, decLd, muxA, muxB, aluSel, shClrN, shLdN, shiftSel, busy, done, error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for exactly the one edge that launches the run
    task automatic startRun(input logic [7:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles since the start edge until done or error, bounded
    task automatic waitEnd(output int n);
        n = 0;
        while (!(done || error) && n < 400) begin
            tick();
            n++;
        end
    endtask

    int cyc;

    initial begin
        rstN  = 1'b0;
        start = 1'b0;
        seed  = 8'd0;
        repeat (3) tick();
        check("reset_word", {9'd0, outWord()}, {9'd0, IDLE_WORD});
        rstN = 1'b1;
        tick();
        check("idle_word", {9'd0, outWord()}, {9'd0, IDLE_WORD});

        // Seed 6: 8 steps, 69 cycles
        startRun(8'd6);
        check("s6_busy", {31'd0, busy}, 32'd1);
        check("s6_clr1", {29'd0, decClr}, {29'd0, DEC_R1});
        waitEnd(cyc);
        check("s6_cycles", cyc, 69);
        check("s6_done", {31'd0, done}, 32'd1);
        check("s6_error", {31'd0, error}, 32'd0);
        check("s6_busy_end", {31'd0, busy}, 32'd0);
        check("s6_r3", {24'd0, dpR[3]}, 32'd8);

        // Seed 1: immediate termination
        startRun(8'd1);
        check("s1_done_drop", {31'd0, done}, 32'd0);
        waitEnd(cyc);
        check("s1_cycles", cyc, 7);
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_r3", {24'd0, dpR[3]}, 32'd0);

        // Seed 0: zero seed error
        startRun(8'd0);
        waitEnd(cyc);
        check("s0_cycles", cyc, 5);
        check("s0_error", {31'd0, error}, 32'd1);
        check("s0_done", {31'd0, done}, 32'd0);
        check("s0_busy", {31'd0, busy}, 32'd0);

        // Seed 255: 255+255 carries in ODD1_A
        startRun(8'd255);
        check("s255_err_drop", {31'd0, error}, 32'd0);
        waitEnd(cyc);
        check("s255_cycles", cyc, 9);
        check("s255_error", {31'd0, error}, 32'd1);
        check("s255_r3", {24'd0, dpR[3]}, 32'd0);

        // Seed 27: 107+214 overflows in ODD2_A after 11 steps
        startRun(8'd27);
        waitEnd(cyc);
        check("s27_cycles", cyc, 103);
        check("s27_error", {31'd0, error}, 32'd1);
        check("s27_done", {31'd0, done}, 32'd0);
        check("s27_r3", {24'd0, dpR[3]}, 32'd11);

        // Asynchronous reset mid-run
        startRun(8'd6);
        repeat (20) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        #3 rstN = 1'b0;
        #1;
        check("async_reset_word", {9'd0, outWord()}, {9'd0, IDLE_WORD});
        tick();
        rstN = 1'b1;
        tick();
        check("post_reset_idle", {9'd0, outWord()}, {9'd0, IDLE_WORD});
        startRun(8'd6);
        waitEnd(cyc);
        check("post_reset_cycles", cyc, 69);
        check("post_reset_r3", {24'd0, dpR[3]}, 32'd8);

        // Start pulse while busy is ignored
        startRun(8'd6);
        repeat (30) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitEnd(cyc);
        check("busy_start_cycles", cyc + 31, 69);
        check("busy_start_r3", {24'd0, dpR[3]}, 32'd8);

        // Start held high through DONE restarts immediately
        seed  = 8'd1;
        start = 1'b1;
        tick();
        waitEnd(cyc);
        check("hold_first_cycles", cyc, 7);
        tick();
        check("hold_restart_busy", {31'd0, busy}, 32'd1);
        check("hold_restart_done", {31'd0, done}, 32'd0);
        waitEnd(cyc);
        check("hold_second_cycles", cyc, 7);
        start = 1'b0;
        tick();
        check("hold_stay_done", {31'd0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
